// File: rtl/pdh_pkg.sv
// Shared constants and DAC word packing helpers for the PDH output path.
package pdh_pkg;

    localparam int DAC_W   = 14;
    localparam int CH0_LSB = 0;
    localparam int CH1_LSB = 16;
    localparam int WORD_W  = 32;

    // Direction a channel is moving on the current tick.
    typedef enum logic [1:0] {
        SLEW_HOLD = 2'b00,
        SLEW_UP   = 2'b01,
        SLEW_DOWN = 2'b10
    } slew_dir_e;

    // Two unpacked DAC lanes.
    typedef struct packed {
        logic [DAC_W-1:0] ch1;
        logic [DAC_W-1:0] ch0;
    } dac_pair_t;

    // Place two codes into their lanes; reserved bits are driven to zero.
    function automatic logic [WORD_W-1:0] pack_dac_word(
        input logic [DAC_W-1:0] ch0,
        input logic [DAC_W-1:0] ch1
    );
        logic [WORD_W-1:0] word;
        word                    = '0;
        word[CH0_LSB +: DAC_W]  = ch0;
        word[CH1_LSB +: DAC_W]  = ch1;
        return word;
    endfunction

    // Extract both lanes from a packed word; reserved bits are ignored.
    function automatic dac_pair_t unpack_dac_word(input logic [WORD_W-1:0] word);
        dac_pair_t pair;
        pair.ch0 = word[CH0_LSB +: DAC_W];
        pair.ch1 = word[CH1_LSB +: DAC_W];
        return pair;
    endfunction

endpackage

// File: rtl/dac_slew_chan.sv
// One DAC channel: target register, current-output register and the
// step-clamped move of the output toward the target.
module dac_slew_chan
    import pdh_pkg::*;
#(
    parameter int CODE_W = DAC_W
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              tick_i,
    input  logic              bypass_i,
    input  logic              tgt_load_i,
    input  logic [CODE_W-1:0] tgt_i,
    input  logic [CODE_W-1:0] step_i,
    output logic [CODE_W-1:0] cur_o,
    output logic              busy_o,
    output logic              changed_o
);

    logic [CODE_W-1:0] tgt_q, tgt_d;
    logic [CODE_W-1:0] cur_q, cur_d;
    logic [CODE_W-1:0] step_eff;
    logic [CODE_W:0]   step_ext;
    logic [CODE_W:0]   diff_up;
    logic [CODE_W:0]   diff_dn;
    logic [CODE_W:0]   delta;
    logic [CODE_W:0]   cur_next_ext;
    slew_dir_e         dir;

    // Capture a new target whenever upstream presents a valid word.
    always_comb begin
        tgt_d = tgt_q;
        if (tgt_load_i) begin
            tgt_d = tgt_i;
        end
    end

    // Work out direction and the clamped step; the distance is one bit wider
    // than the code so neither subtraction can wrap.
    always_comb begin
        step_eff = step_i;
        if (step_i == '0) begin
            step_eff = CODE_W'(1);
        end
        step_ext = {1'b0, step_eff};
        diff_up  = {1'b0, tgt_q} - {1'b0, cur_q};
        diff_dn  = {1'b0, cur_q} - {1'b0, tgt_q};

        dir   = SLEW_HOLD;
        delta = '0;
        if (tgt_q > cur_q) begin
            dir   = SLEW_UP;
            delta = (step_ext < diff_up) ? step_ext : diff_up;
        end else if (tgt_q < cur_q) begin
            dir   = SLEW_DOWN;
            delta = (step_ext < diff_dn) ? step_ext : diff_dn;
        end
    end

    // Next output code: follow the target outright in bypass, otherwise move
    // by the clamped step on a tick, saturating at the code range edges.
    always_comb begin
        cur_d        = cur_q;
        cur_next_ext = {1'b0, cur_q};
        if (bypass_i) begin
            cur_d = tgt_q;
        end else if (tick_i) begin
            case (dir)
                SLEW_UP: begin
                    cur_next_ext = {1'b0, cur_q} + delta;
                    cur_d = cur_next_ext[CODE_W] ? '1 : cur_next_ext[CODE_W-1:0];
                end
                SLEW_DOWN: begin
                    cur_next_ext = {1'b0, cur_q} - delta;
                    cur_d = cur_next_ext[CODE_W] ? '0 : cur_next_ext[CODE_W-1:0];
                end
                default: begin
                    cur_d = cur_q;
                end
            endcase
        end
    end

    // Target and output registers.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            tgt_q <= '0;
            cur_q <= '0;
        end else begin
            tgt_q <= tgt_d;
            cur_q <= cur_d;
        end
    end

    // Status derived from registered state plus the pending change flag.
    always_comb begin
        cur_o     = cur_q;
        busy_o    = (cur_q != tgt_q);
        changed_o = (cur_d != cur_q);
    end

endmodule

// File: rtl/dac_slew_stage.sv
// Rate-limits the packed two-channel DAC stream from pdh_core so actuators
// ramp toward new setpoints instead of stepping; optional pass-through.
module dac_slew_stage #(
    parameter int DAC_W = pdh_pkg::DAC_W,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic [31:0]      s_tdata_i,
    input  logic             s_tvalid_i,
    input  logic [DAC_W-1:0] cfg_step_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic             cfg_bypass_i,
    output logic [31:0]      m_tdata_o,
    output logic             m_tvalid_o,
    output logic [1:0]       busy_o
);

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic              tick;
    logic              valid_q, valid_d;
    pdh_pkg::dac_pair_t tgt_pair;
    logic [DAC_W-1:0]  cur0, cur1;
    logic              busy0, busy1;
    logic              changed0, changed1;

    // Split the incoming word into its two lanes.
    always_comb begin
        tgt_pair = pdh_pkg::unpack_dac_word(s_tdata_i);
    end

    // Free-running tick divider; lowering the period below the count ticks at once.
    always_comb begin
        tick  = (cnt_q >= cfg_div_i);
        cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    end

    // Divider counter register.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    dac_slew_chan #(
        .CODE_W (DAC_W)
    ) u_chan0 (
        .clk        (clk),
        .rst_ni     (rst_ni),
        .tick_i     (tick),
        .bypass_i   (cfg_bypass_i),
        .tgt_load_i (s_tvalid_i),
        .tgt_i      (tgt_pair.ch0),
        .step_i     (cfg_step_i),
        .cur_o      (cur0),
        .busy_o     (busy0),
        .changed_o  (changed0)
    );

    dac_slew_chan #(
        .CODE_W (DAC_W)
    ) u_chan1 (
        .clk        (clk),
        .rst_ni     (rst_ni),
        .tick_i     (tick),
        .bypass_i   (cfg_bypass_i),
        .tgt_load_i (s_tvalid_i),
        .tgt_i      (tgt_pair.ch1),
        .step_i     (cfg_step_i),
        .cur_o      (cur1),
        .busy_o     (busy1),
        .changed_o  (changed1)
    );

    // One pulse per edge where either channel moved, so simultaneous steps merge.
    always_comb begin
        valid_d = changed0 | changed1;
    end

    // Output valid register.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Re-pack the current codes and expose per-channel busy flags.
    always_comb begin
        m_tdata_o  = pdh_pkg::pack_dac_word(cur0, cur1);
        m_tvalid_o = valid_q;
        busy_o     = {busy1, busy0};
    end

endmodule

// File: tb/tb_dac_slew_stage.sv
// Directed bench for dac_slew_stage: vector table plus multi-cycle sequences.
module tb_dac_slew_stage;

    logic        clk;
    logic        rst_ni;
    logic [31:0] s_tdata_i;
    logic        s_tvalid_i;
    logic [13:0] cfg_step_i;
    logic [15:0] cfg_div_i;
    logic        cfg_bypass_i;
    logic [31:0] m_tdata_o;
    logic        m_tvalid_o;
    logic [1:0]  busy_o;

    int total;
    int bad;

    typedef struct {
        string       name;
        logic        vld;
        logic [31:0] data;
        logic        byp;
        logic [13:0] step;
        logic [15:0] div;
        logic [31:0] exp_data;
        logic        exp_vld;
        logic [1:0]  exp_busy;
    } vec_t;

    vec_t vecs[12];

    dac_slew_stage #(
        .DAC_W (14),
        .DIV_W (16)
    ) dut (
        .clk          (clk),
        .rst_ni       (rst_ni),
        .s_tdata_i    (s_tdata_i),
        .s_tvalid_i   (s_tvalid_i),
        .cfg_step_i   (cfg_step_i),
        .cfg_div_i    (cfg_div_i),
        .cfg_bypass_i (cfg_bypass_i),
        .m_tdata_o    (m_tdata_o),
        .m_tvalid_o   (m_tvalid_o),
        .busy_o       (busy_o)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop if something stalls the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic vld, input logic [31:0] data,
                                 input logic byp, input logic [13:0] step,
                                 input logic [15:0] div);
        s_tvalid_i   = vld;
        s_tdata_i    = data;
        cfg_bypass_i = byp;
        cfg_step_i   = step;
        cfg_div_i    = div;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        int last_pulse;
        int peak;
        int jumps;
        int prev;
        int cur;
        logic retargeted;
        logic settled;

        total = 0;
        bad   = 0;

        vecs[0]  = '{"byp_capture", 1'b1, 32'h1ABC0123, 1'b1, 14'h1, 16'h0, 32'h00000000, 1'b0, 2'b11};
        vecs[1]  = '{"byp_follow",  1'b0, 32'h0,        1'b1, 14'h1, 16'h0, 32'h1ABC0123, 1'b1, 2'b00};
        vecs[2]  = '{"byp_quiet",   1'b0, 32'h0,        1'b1, 14'h1, 16'h0, 32'h1ABC0123, 1'b0, 2'b00};
        vecs[3]  = '{"byp_resend",  1'b1, 32'h1ABC0123, 1'b1, 14'h1, 16'h0, 32'h1ABC0123, 1'b0, 2'b00};
        vecs[4]  = '{"byp_resend2", 1'b0, 32'h0,        1'b1, 14'h1, 16'h0, 32'h1ABC0123, 1'b0, 2'b00};
        vecs[5]  = '{"byp_zero",    1'b1, 32'h00000000, 1'b1, 14'h1, 16'h0, 32'h1ABC0123, 1'b0, 2'b11};
        vecs[6]  = '{"byp_zero2",   1'b0, 32'h0,        1'b1, 14'h1, 16'h0, 32'h00000000, 1'b1, 2'b00};
        vecs[7]  = '{"byp_zero3",   1'b0, 32'h0,        1'b1, 14'h1, 16'h0, 32'h00000000, 1'b0, 2'b00};
        vecs[8]  = '{"slew_capt",   1'b1, 32'h00000123, 1'b0, 14'h100, 16'h0, 32'h00000000, 1'b0, 2'b01};
        vecs[9]  = '{"slew_step1",  1'b0, 32'h0,        1'b0, 14'h100, 16'h0, 32'h00000100, 1'b1, 2'b01};
        vecs[10] = '{"slew_step2",  1'b0, 32'h0,        1'b0, 14'h100, 16'h0, 32'h00000123, 1'b1, 2'b00};
        vecs[11] = '{"slew_done",   1'b0, 32'h0,        1'b0, 14'h100, 16'h0, 32'h00000123, 1'b0, 2'b00};

        rst_ni = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 14'h1, 16'h0);
        repeat (3) stepCycle();
        checkOutput("rst_data", m_tdata_o, 32'h0);
        checkOutput("rst_valid", {31'b0, m_tvalid_o}, 32'h0);
        checkOutput("rst_busy", {30'b0, busy_o}, 32'h0);
        rst_ni = 1'b1;
        stepCycle();

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].vld, vecs[i].data, vecs[i].byp, vecs[i].step, vecs[i].div);
            stepCycle();
            checkOutput({vecs[i].name, "_data"}, m_tdata_o, vecs[i].exp_data);
            checkOutput({vecs[i].name, "_valid"}, {31'b0, m_tvalid_o}, {31'b0, vecs[i].exp_vld});
            checkOutput({vecs[i].name, "_busy"}, {30'b0, busy_o}, {30'b0, vecs[i].exp_busy});
        end

        // Slow ramp down on ch1: park ch1 at 5 through bypass, then step=1, div=3.
        applyStimulus(1'b1, 32'h00050000, 1'b1, 14'h1, 16'h0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 14'h1, 16'h0);
        stepCycle();
        stepCycle();
        checkOutput("div_setup", m_tdata_o, 32'h00050000);
        applyStimulus(1'b1, 32'h00000000, 1'b0, 14'h1, 16'h3);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 14'h1, 16'h3);
        pulses     = 0;
        last_pulse = 0;
        for (int i = 0; i < 40; i++) begin
            stepCycle();
            if (m_tvalid_o) begin
                pulses++;
                checkOutput("div_value", m_tdata_o, (32'(5 - pulses)) << 16);
                if (pulses > 1) begin
                    checkOutput("div_gap", 32'(i - last_pulse), 32'd4);
                end
                last_pulse = i;
            end
        end
        checkOutput("div_pulses", 32'(pulses), 32'd5);
        checkOutput("div_final", m_tdata_o, 32'h00000000);
        checkOutput("div_busy", {30'b0, busy_o}, 32'h0);

        // Retarget mid-ramp: head for 0x40, turn back to 0x10 once at 0x20.
        applyStimulus(1'b1, 32'h00000040, 1'b0, 14'h1, 16'h0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 14'h1, 16'h0);
        retargeted = 1'b0;
        settled    = 1'b0;
        peak       = 0;
        jumps      = 0;
        prev       = 0;
        for (int i = 0; i < 200; i++) begin
            stepCycle();
            cur = int'(m_tdata_o[13:0]);
            if ((cur - prev > 1) || (prev - cur > 1)) begin
                jumps++;
            end
            prev = cur;
            if (retargeted && cur > peak) begin
                peak = cur;
            end
            if (!retargeted && cur == 32'h20) begin
                applyStimulus(1'b1, 32'h00000010, 1'b0, 14'h1, 16'h0);
                retargeted = 1'b1;
            end else begin
                applyStimulus(1'b0, 32'h0, 1'b0, 14'h1, 16'h0);
            end
            if (retargeted && cur == 32'h10 && busy_o == 2'b00) begin
                settled = 1'b1;
                break;
            end
        end
        checkOutput("rt_settled", {31'b0, settled}, 32'd1);
        checkOutput("rt_jumps", 32'(jumps), 32'd0);
        checkOutput("rt_peak", 32'(peak), 32'h21);
        checkOutput("rt_final", m_tdata_o, 32'h00000010);

        // Asynchronous reset in the middle of a ramp.
        applyStimulus(1'b1, 32'h00003FFF, 1'b0, 14'h1, 16'h0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 14'h1, 16'h0);
        repeat (5) stepCycle();
        checkOutput("ramp_busy", {30'b0, busy_o}, 32'h1);
        #3;
        rst_ni = 1'b0;
        #1;
        checkOutput("arst_data", m_tdata_o, 32'h0);
        checkOutput("arst_valid", {31'b0, m_tvalid_o}, 32'h0);
        checkOutput("arst_busy", {30'b0, busy_o}, 32'h0);
        repeat (2) stepCycle();
        rst_ni = 1'b1;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            stepCycle();
            if (m_tvalid_o) begin
                pulses++;
            end
        end
        checkOutput("post_rst_pulses", 32'(pulses), 32'd0);
        checkOutput("post_rst_data", m_tdata_o, 32'h0);

        // step=0 behaves as 1; both channels share each pulse.
        applyStimulus(1'b1, 32'h00030003, 1'b0, 14'h0, 16'h0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 14'h0, 16'h0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            if (m_tvalid_o) begin
                pulses++;
                checkOutput("dual_value", m_tdata_o, (32'(pulses) << 16) | 32'(pulses));
            end
        end
        checkOutput("dual_pulses", 32'(pulses), 32'd3);
        checkOutput("dual_final", m_tdata_o, 32'h00030003);
        checkOutput("dual_busy", {30'b0, busy_o}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
